cordic_avalon_buffered: RTL
===========================

# cordic_avalon_buffered

Avalon-MM slave around a parametrised, internally generated CORDIC sine/cosine pipeline. It adds a result FIFO, credit-based write backpressure, a status/control register map and an optional interrupt. It sits on the Nios/Avalon fabric as the next generation of the lab's single-register CORDIC peripheral, and allows back-to-back angle writes without losing results.

## Interface
- W, 12: angle/sin/cos width. Legal range 8..16.
- STAGES, 12: CORDIC iteration stages. Legal range 4..W.
- DEPTH, 8: result FIFO depth. Power of two, 2..64.
- clock  in  1: system clock. Single clock domain.
- resetn  in  1: reset, asynchronous, active-low.
- chipselect  in  1: Avalon slave select.
- address  in  2: register select. 0 ANGLE, 1 RESULT, 2 STATUS, 3 CONTROL.
- write  in  1: write strobe.
- read  in  1: read strobe.
- writedata  in  32: write data.
- readdata  out  32: read data, registered, read latency 1.
- waitrequest  out  1: stalls ANGLE writes when no credit is available.
- sincos_export  out  32: last completed result, {cos sign-extended to 16 bits, sin sign-extended to 16 bits}.
- valid_export  out  1: one-cycle pulse per completed result.
- irq  out  1: interrupt request. Tied 0 unless CORDIC_IRQ_EN is defined.

## Operation
- **Angle format:** signed Q2.(W-2) radians, taken from writedata[W-1:0]. Valid range is ±π/2; inputs outside it give unspecified results.
- **Output format:** sin/cos are signed Q1.(W-2).
- **Initial vector:** x0 = round(0.607253·2^(W-2)), y0 = 0, z0 = angle.
- **Stage i:** shift by i; arctan constant atan(2^-i) in Q2.(W-2). Internal datapath is W+2 bits wide and saturates to W bits at the output.
- **Pipeline:** STAGES registered stages plus one input register. A valid bit travels with each sample. The pipeline never stalls.
- **ANGLE write (addr 0):** accepted when credit > 0, where credit = DEPTH − fifo_count − inflight. When credit = 0, waitrequest stays high until credit frees.
- **ANGLE read (addr 0):** returns the last accepted angle, sign-extended.
- **RESULT read (addr 1):** returns the FIFO head and pops it. On an empty FIFO it returns 0 and sets sticky `underflow`.
- **STATUS (addr 2), read-only bit map:**
  - [0] empty
  - [1] full
  - [2] underflow
  - [3] busy (inflight ≠ 0)
  - [14:8] fifo_count
  - [22:16] inflight
- **CONTROL (addr 3), write:**
  - bit0 clear: flushes the FIFO, zeroes all pipeline valid bits and clears `underflow`.
  - [14:8] irq_threshold.
- **CONTROL (addr 3), read:** returns the same fields; bit0 reads 0.
- **Simultaneous push and pop:** both occur; count is unchanged.
- **Clear vs. ANGLE write in the same cycle:** clear wins; the write is accepted but discarded.
- Writes to RESULT/STATUS and reads of CONTROL bit0 have no effect.

## Timing
- **Reset values:** readdata = 0, waitrequest = 0, sincos_export = 0, valid_export = 0, irq = 0. FIFO is empty, inflight = 0, irq_threshold = 1, underflow = 0.
- **Reset mid-operation:** all in-flight samples and FIFO contents are lost immediately (asynchronous).
- **Write-to-result latency:** an ANGLE write accepted at edge N pushes its result into the FIFO at edge N+STAGES+1.
- **Exports:** sincos_export and valid_export update at the same edge as the FIFO push.
- **Read timing:** readdata is valid one cycle after the read is sampled. The pop takes effect at the read-sampling edge.
- **waitrequest** is combinational: chipselect & write & (address == 0) & (credit == 0).
- **Throughput:** one result per clock.

## Configuration
- **CORDIC_IRQ_EN defined:** irq is registered high while fifo_count ≥ irq_threshold, or while underflow is set. It deasserts one cycle after the condition clears.
- **CORDIC_IRQ_EN undefined:** irq = 0 constantly. Threshold bits still read and write as normal.

## Test plan
- **Reset, then single write (W = 12):** write ANGLE = 0 → after 13 cycles valid_export pulses; RESULT read gives cos = 1024 ±2, sin = 0 ±2. STATUS is then empty = 1.
- **π/4 check:** write ANGLE = 804 → sin = cos = 724 ±2. Write −804 → sin = −724 ±2, cos = 724 ±2.
- **Burst backpressure (DEPTH = 8):** write 10 angles back-to-back with no reads → waitrequest asserts on the 9th write. After one RESULT read, waitrequest drops one cycle later and the write completes. All results return in order.
- **Underflow:** read RESULT on an empty FIFO → readdata = 0, STATUS[2] = 1. A CONTROL write of 1 clears it.
- **Clear with 3 samples in flight:** write CONTROL = 1 → no valid_export pulses follow, STATUS reads empty = 1 and busy = 0.
- **Interrupt (CORDIC_IRQ_EN):** threshold = 2, write 2 angles → irq rises one cycle after the second push. One RESULT read drops irq one cycle later.

Source files
------------

// File: rtl/cordic_avalon_buffered.sv
// rtl/cordic_avalon_buffered.sv - Avalon-MM CORDIC sine/cosine with result FIFO and credit backpressure
// Optional registered interrupt is built when CORDIC_IRQ_EN is defined.
module cordic_avalon_buffered #(
  parameter int W      = 12,
  parameter int STAGES = 12,
  parameter int DEPTH  = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [31:0] sincos_export,
  output logic        valid_export,
  output logic        irq
);
  localparam int DW = W + 2;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = 7;

  typedef logic signed [DW-1:0] dp_t;

  // The two extra datapath bits sit below the Q(W-2) point as guard bits, so
  // per-stage shift truncation stays well below one output LSB.
  localparam longint X0_Q = ((longint'(607253) << (W - 2)) + 64'sd500000) / 64'sd1000000;
  localparam dp_t    X0   = dp_t'(X0_Q << 2);

  localparam logic signed [DW:0] SMAX = (DW+1)'((1 << (W - 1)) - 1);
  localparam logic signed [DW:0] SMIN = (DW+1)'(-(1 << (W - 1)));

  // atan(2^-i) in units of 2^-16 rad, rounded to Q2.(W-2) then placed on the guard-bit grid.
  function automatic dp_t atan_q(input int i);
    int q16;
    int sh;
    case (i)
      0:       q16 = 51472;
      1:       q16 = 30386;
      2:       q16 = 16055;
      3:       q16 = 8150;
      4:       q16 = 4091;
      5:       q16 = 2047;
      6:       q16 = 1024;
      7:       q16 = 512;
      8:       q16 = 256;
      9:       q16 = 128;
      10:      q16 = 64;
      11:      q16 = 32;
      12:      q16 = 16;
      13:      q16 = 8;
      14:      q16 = 4;
      15:      q16 = 2;
      default: q16 = 0;
    endcase
    sh = 18 - W;
    return dp_t'(((q16 + (1 << (sh - 1))) >> sh) << 2);
  endfunction

  function automatic logic [W-1:0] sat_out(input dp_t v);
    logic signed [DW:0] r;
    r = {v[DW-1], v};
    r = (r + (DW+1)'(2)) >>> 2;
    if (r > SMAX)      return SMAX[W-1:0];
    else if (r < SMIN) return SMIN[W-1:0];
    else               return r[W-1:0];
  endfunction

  logic          angle_wr, ctrl_wr, clr, rd_result;
  logic          no_credit, accept, push, pop;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count, inflight;
  logic [CW:0]   used;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [6:0]    irq_thr;
  logic          underflow;
  logic [W-1:0]  last_angle;

  assign angle_wr  = chipselect && write && (address == 2'd0);
  assign ctrl_wr   = chipselect && write && (address == 2'd3);
  assign rd_result = chipselect && read && (address == 2'd1);
  assign clr       = ctrl_wr && writedata[0];

  assign used        = {1'b0, fifo_count} + {1'b0, inflight};
  assign no_credit   = (used >= (CW+1)'(DEPTH));
  assign waitrequest = angle_wr && no_credit;
  assign accept      = angle_wr && !no_credit;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CW'(DEPTH));

  dp_t             xs [STAGES+1];
  dp_t             ys [STAGES+1];
  dp_t             zs [STAGES+1];
  logic [STAGES:0] vld;

  // Index 0 is the input register; index i+1 holds the output of rotation stage i.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld <= '0;
      for (int i = 0; i <= STAGES; i++) begin
        xs[i] <= '0;
        ys[i] <= '0;
        zs[i] <= '0;
      end
    end else begin
      vld[0] <= accept;
      if (accept) begin
        xs[0] <= X0;
        ys[0] <= '0;
        zs[0] <= dp_t'($signed(writedata[W-1:0])) <<< 2;
      end
      for (int i = 0; i < STAGES; i++) begin
        vld[i+1] <= vld[i];
        if (zs[i][DW-1]) begin
          xs[i+1] <= xs[i] + (ys[i] >>> i);
          ys[i+1] <= ys[i] - (xs[i] >>> i);
          zs[i+1] <= zs[i] + atan_q(i);
        end else begin
          xs[i+1] <= xs[i] - (ys[i] >>> i);
          ys[i+1] <= ys[i] + (xs[i] >>> i);
          zs[i+1] <= zs[i] - atan_q(i);
        end
      end
      if (clr) vld <= '0;
    end
  end

  logic signed [W-1:0] cos_w, sin_w;
  logic [31:0]         result_word;
  logic [31:0]         status_word;

  assign cos_w       = sat_out(xs[STAGES]);
  assign sin_w       = sat_out(ys[STAGES]);
  assign result_word = {16'(cos_w), 16'(sin_w)};
  assign status_word = {9'd0, inflight, 1'b0, fifo_count, 4'd0,
                        (inflight != '0), underflow, fifo_full, fifo_empty};

  assign push = vld[STAGES] && !clr;
  assign pop  = rd_result && !fifo_empty && !clr;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= result_word;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      inflight      <= '0;
      underflow     <= 1'b0;
      irq_thr       <= 7'd1;
      last_angle    <= '0;
      readdata      <= '0;
      sincos_export <= '0;
      valid_export  <= 1'b0;
    end else begin
      valid_export <= push;
      if (push) sincos_export <= result_word;

      if (clr) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        inflight   <= '0;
        underflow  <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
        inflight   <= inflight + CW'(accept) - CW'(vld[STAGES]);
        if (rd_result && fifo_empty) underflow <= 1'b1;
      end

      if (ctrl_wr) irq_thr <= writedata[14:8];
      if (accept)  last_angle <= writedata[W-1:0];

      if (chipselect && read) begin
        case (address)
          2'd0:    readdata <= 32'($signed(last_angle));
          2'd1:    readdata <= fifo_empty ? 32'd0 : mem[rd_ptr];
          2'd2:    readdata <= status_word;
          default: readdata <= {17'd0, irq_thr, 8'd0};
        endcase
      end
    end
  end

`ifdef CORDIC_IRQ_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) irq <= 1'b0;
    else         irq <= (fifo_count >= irq_thr) || underflow;
  end
`else
  assign irq = 1'b0;
`endif

  logic unused_sink;
  assign unused_sink = ^{writedata, zs[STAGES]};

endmodule
